// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared definitions for the gshare branch predictor: branch
//               opcode constants, index-mode encoding and the branch decode
//               helper used on both the fetch and resolve sides.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Opcode patterns: bal uses the full 6-bit major opcode, the bs family
    // only the top 4 bits.
    localparam logic [5:0] BAL_OP = 6'b000001;
    localparam logic [3:0] BS_OP  = 4'b0001;

    // Index-mode encoding for the MODE parameter.
    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Counter-table FSM state type (one bit: INIT sweep or RUN).
    typedef logic [0:0] tbl_state_t;

    // Branch decode on the top opcode bits (inst[31:26]).
    function automatic logic is_branch(input logic [5:0] op);
        return (op == BAL_OP) || (op[5:2] == BS_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_counter_table.sv
`default_nettype none
// ============================================================================
// Module      : bp_counter_table
// Description : 2**IDX_W saturating-counter RAM with one combinational read
//               port and one read-modify-write update port. After reset an
//               INIT sweep writes every entry with the weakly-not-taken value,
//               one entry per cycle; ready rises once the sweep is complete.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               rd_idx/rd_data - combinational read (old value on collision)
//               wr_en/wr_idx/wr_taken - saturating increment / decrement
//               ready         - sweep finished, table usable
// Revision    : 1.0 - initial release
// ============================================================================
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 12,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CW-1:0]    rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    output logic             ready
);

    localparam int              c_DEPTH    = 2 ** IDX_W;
    localparam logic [CW-1:0]   c_INIT_VAL = CW'((2 ** (CW - 1)) - 1);
    localparam logic [CW-1:0]   c_CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]   c_CNT_MIN  = {CW{1'b0}};
    localparam logic [IDX_W-1:0] c_LAST_PTR = {IDX_W{1'b1}};

    localparam tbl_state_t c_ST_INIT = 1'b0;
    localparam tbl_state_t c_ST_RUN  = 1'b1;

    logic [CW-1:0]    r_mem [c_DEPTH];
    tbl_state_t       r_state;
    tbl_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic             w_sweep_we;
    logic             w_ready;
    logic [CW-1:0]    w_wr_old;
    logic [CW-1:0]    w_wr_new;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic; leave INIT on the cycle the last entry is
    // written, so ready appears the cycle after that write.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: begin
                if (r_ptr == c_LAST_PTR) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_state_nxt = c_ST_RUN;
            end
            default: begin
                w_state_nxt = c_ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_sweep_we = 1'b0;
        w_ready    = 1'b0;
        case (r_state)
            c_ST_INIT: w_sweep_we = 1'b1;
            c_ST_RUN:  w_ready    = 1'b1;
            default:   w_sweep_we = 1'b0;
        endcase
    end

    // Sweep pointer; wraps back to zero after the last entry and then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_sweep_we) begin
            r_ptr <= r_ptr + IDX_W'(1);
        end
    end

    // Saturating next value for the update port.
    always_comb begin
        w_wr_old = r_mem[wr_idx];
        w_wr_new = w_wr_old;
        if (wr_taken) begin
            if (w_wr_old != c_CNT_MAX) begin
                w_wr_new = w_wr_old + CW'(1);
            end
        end else begin
            if (w_wr_old != c_CNT_MIN) begin
                w_wr_new = w_wr_old - CW'(1);
            end
        end
    end

    // Table storage has no reset of its own: the sweep initialises it.
    // Updates are only honoured outside the sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_sweep_we) begin
                r_mem[r_ptr] <= c_INIT_VAL;
            end else if (wr_en) begin
                r_mem[wr_idx] <= w_wr_new;
            end
        end
    end

    // Plain array read: a same-cycle write to this entry is not bypassed.
    assign rd_data = r_mem[rd_idx];
    assign ready   = w_ready;

endmodule
`default_nettype wire

// File: rtl/gshare_branch_pre.sv
`default_nettype none
// ============================================================================
// Module      : gshare_branch_pre
// Description : Gshare / bimodal branch direction predictor. Prediction is
//               combinational from a table of CW-bit saturating counters,
//               indexed by PC XOR global history (MODE=1) or PC alone
//               (MODE=0). Holds the speculative GHR with mispredict recovery
//               and the correct-prediction / branch performance counters.
// Ports       : clk, rst                    - clock, sync active-high reset
//               fetch_en/addr/inst          - IF/ID side
//               pred_valid/taken/index/ghr  - prediction, index and GHR
//                                             snapshot carried down the pipe
//               upd_en/inst/index/ghr/pred/taken - resolve-stage update
//               ready                       - table init sweep finished
//               correct_cnt, branch_cnt     - wrapping 32-bit counters
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_branch_pre
    import bp_pkg::*;
#(
    parameter int IDX_W  = 12,
    parameter int HIST_W = 8,
    parameter int CW     = 2,
    parameter int MODE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [31:0]       fetch_addr,
    input  logic [31:0]       fetch_inst,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_index,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_en,
    input  logic [31:0]       upd_inst,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_pred,
    input  logic              upd_taken,
    output logic              ready,
    output logic [31:0]       correct_cnt,
    output logic [31:0]       branch_cnt
);

    logic [HIST_W-1:0] r_ghr;
    logic [31:0]       r_correct_cnt;
    logic [31:0]       r_branch_cnt;

    logic              w_ready;
    logic [CW-1:0]     w_rd_cnt;
    logic [IDX_W-1:0]  w_pc_idx;
    logic [IDX_W-1:0]  w_idx;
    logic              w_fetch_br;
    logic              w_upd_br;
    logic              w_pred_valid;
    logic              w_pred_taken;
    logic              w_upd_q;
    logic              w_upd_hit;
    logic              w_mispred;
    logic              w_spec;
    logic [HIST_W-1:0] w_ghr_spec;
    logic [HIST_W-1:0] w_ghr_rec;

    // Bits of the wide buses that the predictor does not look at.
    logic              w_unused_ok;
    assign w_unused_ok = ^{fetch_addr[31:IDX_W+2], fetch_addr[1:0],
                           fetch_inst[25:0], upd_inst[25:0], upd_ghr};

    assign w_fetch_br = is_branch(fetch_inst[31:26]);
    assign w_upd_br   = is_branch(upd_inst[31:26]);
    assign w_pc_idx   = fetch_addr[IDX_W+1:2];

    generate
        if (MODE == MODE_GSHARE) begin : g_gshare
            assign w_idx = w_pc_idx ^ IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_idx = w_pc_idx;
        end
    endgenerate

    bp_counter_table #(
        .IDX_W (IDX_W),
        .CW    (CW)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (w_idx),
        .rd_data  (w_rd_cnt),
        .wr_en    (w_upd_q),
        .wr_idx   (upd_index),
        .wr_taken (upd_taken),
        .ready    (w_ready)
    );

    // Everything is frozen until the sweep has finished.
    assign w_pred_valid = w_fetch_br & w_ready;
    assign w_pred_taken = w_pred_valid & w_rd_cnt[CW-1];
    assign w_upd_q      = upd_en & w_upd_br & w_ready;
    assign w_upd_hit    = w_upd_q & (upd_taken == upd_pred);
    assign w_mispred    = w_upd_q & (upd_taken != upd_pred);
    assign w_spec       = fetch_en & w_pred_valid;

    // History shift candidates; a 1-bit history just loads the new outcome.
    generate
        if (HIST_W == 1) begin : g_hist_bit
            assign w_ghr_spec = w_pred_taken;
            assign w_ghr_rec  = upd_taken;
        end else begin : g_hist_shift
            assign w_ghr_spec = {r_ghr[HIST_W-2:0], w_pred_taken};
            assign w_ghr_rec  = {upd_ghr[HIST_W-2:0], upd_taken};
        end
    endgenerate

    // Recovery rebuilds history from the snapshot the mispredicted branch
    // carried, and takes priority over a same-cycle speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_mispred) begin
            r_ghr <= w_ghr_rec;
        end else if (w_spec) begin
            r_ghr <= w_ghr_spec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_correct_cnt <= '0;
            r_branch_cnt  <= '0;
        end else begin
            if (w_upd_hit) begin
                r_correct_cnt <= r_correct_cnt + 32'd1;
            end
            if (w_spec) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
        end
    end

    assign pred_valid  = w_pred_valid;
    assign pred_taken  = w_pred_taken;
    assign pred_index  = w_idx;
    assign pred_ghr    = r_ghr;
    assign ready       = w_ready;
    assign correct_cnt = r_correct_cnt;
    assign branch_cnt  = r_branch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_pre.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_branch_pre
// Description : Directed self-checking bench. Two predictors (MODE=0 and
//               MODE=1, IDX_W=4, HIST_W=4, CW=2) share the stimulus; each
//               step queues its expected outputs and the queue is drained
//               against the DUT mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_branch_pre;

    localparam int IDX_W  = 4;
    localparam int HIST_W = 4;
    localparam int CW     = 2;

    localparam logic [31:0] c_BAL = 32'h0400_0000;
    localparam logic [31:0] c_BS  = 32'h1000_0000;
    localparam logic [31:0] c_NOP = 32'h0000_0000;

    logic              clk;
    logic              rst;
    logic              fetch_en;
    logic [31:0]       fetch_addr;
    logic [31:0]       fetch_inst;
    logic              upd_en;
    logic [31:0]       upd_inst;
    logic [IDX_W-1:0]  upd_index;
    logic [HIST_W-1:0] upd_ghr;
    logic              upd_pred;
    logic              upd_taken;

    logic              m0_pred_valid, m1_pred_valid;
    logic              m0_pred_taken, m1_pred_taken;
    logic [IDX_W-1:0]  m0_pred_index, m1_pred_index;
    logic [HIST_W-1:0] m0_pred_ghr,   m1_pred_ghr;
    logic              m0_ready,      m1_ready;
    logic [31:0]       m0_correct_cnt, m1_correct_cnt;
    logic [31:0]       m0_branch_cnt,  m1_branch_cnt;

    gshare_branch_pre #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CW(CW), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_inst(fetch_inst), .pred_valid(m0_pred_valid), .pred_taken(m0_pred_taken),
        .pred_index(m0_pred_index), .pred_ghr(m0_pred_ghr), .upd_en(upd_en),
        .upd_inst(upd_inst), .upd_index(upd_index), .upd_ghr(upd_ghr),
        .upd_pred(upd_pred), .upd_taken(upd_taken), .ready(m0_ready),
        .correct_cnt(m0_correct_cnt), .branch_cnt(m0_branch_cnt)
    );

    gshare_branch_pre #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CW(CW), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_inst(fetch_inst), .pred_valid(m1_pred_valid), .pred_taken(m1_pred_taken),
        .pred_index(m1_pred_index), .pred_ghr(m1_pred_ghr), .upd_en(upd_en),
        .upd_inst(upd_inst), .upd_index(upd_index), .upd_ghr(upd_ghr),
        .upd_pred(upd_pred), .upd_taken(upd_taken), .ready(m1_ready),
        .correct_cnt(m1_correct_cnt), .branch_cnt(m1_branch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_READY, S_PVALID, S_PTAKEN, S_PINDEX, S_PGHR, S_CCNT, S_BCNT} sig_e;
    typedef struct {
        string       tag;
        int          dut;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(int d, sig_e s);
        case (s)
            S_READY:  return d != 0 ? 32'(m1_ready)       : 32'(m0_ready);
            S_PVALID: return d != 0 ? 32'(m1_pred_valid)  : 32'(m0_pred_valid);
            S_PTAKEN: return d != 0 ? 32'(m1_pred_taken)  : 32'(m0_pred_taken);
            S_PINDEX: return d != 0 ? 32'(m1_pred_index)  : 32'(m0_pred_index);
            S_PGHR:   return d != 0 ? 32'(m1_pred_ghr)    : 32'(m0_pred_ghr);
            S_CCNT:   return d != 0 ? m1_correct_cnt      : m0_correct_cnt;
            default:  return d != 0 ? m1_branch_cnt       : m0_branch_cnt;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int d, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.sig = s;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.dut, e.sig);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s (dut%0d): observed 0x%0h expected 0x%0h", e.tag, e.dut, obs, e.exp);
            end
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
        drain();
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (n < 40 && observe(d, S_READY) != 32'd1) begin
            cyc();
            n++;
        end
        push_exp("ready_timeout", d, S_READY, 32'd1);
        settle();
    endtask

    task automatic set_upd(input logic en, input logic [31:0] inst, input logic [3:0] idx,
                           input logic [3:0] ghr, input logic pred, input logic taken);
        upd_en    = en;
        upd_inst  = inst;
        upd_index = idx;
        upd_ghr   = ghr;
        upd_pred  = pred;
        upd_taken = taken;
    endtask

    // MODE=0 saturation walk: outcome, supplied prediction, expected
    // pred_taken afterwards, expected correct_cnt afterwards.
    localparam logic [4:0] c_W_TAKEN = 5'b00111;
    localparam logic [4:0] c_W_PRED  = 5'b11110;
    localparam logic [4:0] c_W_PT    = 5'b01111;
    localparam int         c_W_CC [5] = '{0, 1, 2, 2, 2};

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] w_taken;
        logic [4:0] w_pred;
        logic [4:0] w_pt;
        w_taken = c_W_TAKEN;
        w_pred  = c_W_PRED;
        w_pt    = c_W_PT;

        // ---------------- reset, sweep and sweep restart ----------------
        rst        = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = 32'h0;
        fetch_inst = c_BAL;
        set_upd(1'b0, c_NOP, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc();
        for (int d = 0; d < 2; d++) begin
            push_exp("rst_ready", d, S_READY, 32'd0);
            push_exp("rst_pvalid", d, S_PVALID, 32'd0);
            push_exp("rst_ptaken", d, S_PTAKEN, 32'd0);
            push_exp("rst_ghr", d, S_PGHR, 32'd0);
            push_exp("rst_ccnt", d, S_CCNT, 32'd0);
            push_exp("rst_bcnt", d, S_BCNT, 32'd0);
        end
        settle();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_exp("sweep_ready", 1, S_READY, 32'd0);
            push_exp("sweep_ready", 0, S_READY, 32'd0);
            push_exp("sweep_pvalid", 1, S_PVALID, 32'd0);
            push_exp("sweep_ptaken", 1, S_PTAKEN, 32'd0);
            settle();
            cyc();
        end
        push_exp("sweep_done", 0, S_READY, 32'd1);
        push_exp("sweep_done", 1, S_READY, 32'd1);
        push_exp("sweep_bcnt", 1, S_BCNT, 32'd0);
        push_exp("sweep_bcnt", 0, S_BCNT, 32'd0);
        settle();
        fetch_en   = 1'b0;
        fetch_inst = c_NOP;

        // ---------------- MODE=0 saturating counter walk ----------------
        fetch_inst = c_BS;
        fetch_addr = 32'h10;
        push_exp("bim_index", 0, S_PINDEX, 32'd4);
        push_exp("bim_pvalid", 0, S_PVALID, 32'd1);
        push_exp("bim_init_pt", 0, S_PTAKEN, 32'd0);
        settle();
        for (int i = 0; i < 5; i++) begin
            set_upd(1'b1, c_BS, 4'd4, 4'h0, w_pred[i], w_taken[i]);
            cyc();
            set_upd(1'b0, c_BS, 4'd4, 4'h0, 1'b0, 1'b0);
            push_exp($sformatf("bim_pt_%0d", i), 0, S_PTAKEN, 32'(w_pt[i]));
            push_exp($sformatf("bim_cc_%0d", i), 0, S_CCNT, 32'(c_W_CC[i]));
            settle();
        end
        push_exp("bim_bcnt_noen", 0, S_BCNT, 32'd0);
        settle();

        // ---------------- MODE=1: fresh start ----------------
        fetch_inst = c_NOP;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_ready(1);
        push_exp("gs_rst_ghr", 1, S_PGHR, 32'd0);
        push_exp("gs_rst_ccnt", 1, S_CCNT, 32'd0);
        settle();

        // Train entry 6 to weakly taken (correct prediction, GHR untouched).
        set_upd(1'b1, c_BS, 4'd6, 4'h0, 1'b1, 1'b1);
        cyc();
        push_exp("gs_train_ccnt", 1, S_CCNT, 32'd1);
        push_exp("gs_train_ghr", 1, S_PGHR, 32'd0);
        settle();

        // Mispredict recovery loads GHR = {001,1}.
        set_upd(1'b1, c_BS, 4'd15, 4'b0001, 1'b0, 1'b1);
        cyc();
        set_upd(1'b0, c_NOP, 4'd0, 4'h0, 1'b0, 1'b0);
        push_exp("gs_setghr", 1, S_PGHR, 32'h3);
        push_exp("gs_setghr_ccnt", 1, S_CCNT, 32'd1);
        settle();

        // Index hash: 0x14 -> 0101 ^ 0011 = 0110.
        fetch_inst = c_BS;
        fetch_addr = 32'h14;
        push_exp("gs_index", 1, S_PINDEX, 32'h6);
        push_exp("gs_pghr", 1, S_PGHR, 32'h3);
        push_exp("gs_pvalid", 1, S_PVALID, 32'd1);
        push_exp("gs_ptaken", 1, S_PTAKEN, 32'd1);
        settle();
        fetch_en = 1'b1;
        cyc();
        fetch_en = 1'b0;
        push_exp("gs_spec_ghr", 1, S_PGHR, 32'h7);
        push_exp("gs_spec_bcnt", 1, S_BCNT, 32'd1);
        settle();

        // Branch seen with fetch_en low: nothing moves.
        cyc();
        push_exp("gs_noen_ghr", 1, S_PGHR, 32'h7);
        push_exp("gs_noen_bcnt", 1, S_BCNT, 32'd1);
        settle();

        // Mispredict with a simultaneous counted fetch: recovery wins.
        fetch_en = 1'b1;
        set_upd(1'b1, c_BS, 4'd6, 4'b1010, 1'b1, 1'b0);
        cyc();
        fetch_en = 1'b0;
        set_upd(1'b0, c_NOP, 4'd0, 4'h0, 1'b0, 1'b0);
        push_exp("gs_rec_ghr", 1, S_PGHR, 32'h4);
        push_exp("gs_rec_ccnt", 1, S_CCNT, 32'd1);
        push_exp("gs_rec_bcnt", 1, S_BCNT, 32'd2);
        settle();

        // 0x08 -> 0010 ^ 0100 = 0110: entry 6 decremented to 01.
        fetch_addr = 32'h08;
        push_exp("gs_dec_index", 1, S_PINDEX, 32'h6);
        push_exp("gs_dec_pt", 1, S_PTAKEN, 32'd0);
        settle();

        // Same-entry read and write: old value this cycle, new one next.
        set_upd(1'b1, c_BS, 4'd6, 4'h4, 1'b1, 1'b1);
        push_exp("gs_rw_old", 1, S_PTAKEN, 32'd0);
        settle();
        cyc();
        set_upd(1'b0, c_BS, 4'd6, 4'h4, 1'b1, 1'b0);
        push_exp("gs_rw_new", 1, S_PTAKEN, 32'd1);
        push_exp("gs_rw_ccnt", 1, S_CCNT, 32'd2);
        settle();

        // Non-branch update, then a branch with upd_en low: no effect.
        set_upd(1'b1, c_NOP, 4'd6, 4'h9, 1'b1, 1'b0);
        cyc();
        push_exp("gs_nop_pt", 1, S_PTAKEN, 32'd1);
        push_exp("gs_nop_ghr", 1, S_PGHR, 32'h4);
        push_exp("gs_nop_ccnt", 1, S_CCNT, 32'd2);
        settle();
        set_upd(1'b0, c_BS, 4'd6, 4'h9, 1'b1, 1'b0);
        cyc();
        push_exp("gs_noupd_pt", 1, S_PTAKEN, 32'd1);
        push_exp("gs_noupd_ghr", 1, S_PGHR, 32'h4);
        push_exp("gs_noupd_ccnt", 1, S_CCNT, 32'd2);
        settle();

        // Walk entry 6 down to 00 and try to go below it, then back up.
        for (int i = 0; i < 3; i++) begin
            set_upd(1'b1, c_BS, 4'd6, 4'h4, 1'b0, 1'b0);
            cyc();
            push_exp($sformatf("gs_down_pt_%0d", i), 1, S_PTAKEN, 32'd0);
            push_exp($sformatf("gs_down_cc_%0d", i), 1, S_CCNT, 32'(3 + i));
            settle();
        end
        for (int i = 0; i < 2; i++) begin
            set_upd(1'b1, c_BS, 4'd6, 4'h4, 1'b1, 1'b1);
            cyc();
            push_exp($sformatf("gs_up_pt_%0d", i), 1, S_PTAKEN, 32'(i));
            push_exp($sformatf("gs_up_cc_%0d", i), 1, S_CCNT, 32'(6 + i));
            settle();
        end
        set_upd(1'b0, c_NOP, 4'd0, 4'h0, 1'b0, 1'b0);
        push_exp("gs_end_bcnt", 1, S_BCNT, 32'd2);
        push_exp("gs_end_ghr", 1, S_PGHR, 32'h4);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_branch_pre.md
Name: gshare_branch_pre

Overview:
- Parametrised successor to the bimodal 2-bit predictor; sits beside IF/ID and the branch resolve stage.
- Reads a table of saturating counters indexed by PC XOR global history (MODE=1) or by PC alone (MODE=0).
- Keeps a speculative global history register (GHR) with misprediction recovery and a reset-time table-init sweep.
- Provides correct-prediction and branch performance counters.

Parameters:
- IDX_W, 12, table index width; depth = 2**IDX_W entries.
- HIST_W, 8, GHR width; legal range 1..IDX_W.
- CW, 2, counter width; legal range 2..4.
- MODE, 1, 0 = bimodal index, 1 = gshare index.

Ports:
- clk  in  1  clock, single domain
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  IF/ID write enable; fetch-side events count only when 1
- fetch_addr  in  32  fetch PC
- fetch_inst  in  32  fetched instruction
- pred_valid  out  1  fetch_inst is a branch and ready=1
- pred_taken  out  1  predicted direction; 0 when pred_valid=0
- pred_index  out  IDX_W  table index used for this prediction; carried down the pipe
- pred_ghr  out  HIST_W  GHR value before this prediction's shift; carried down the pipe
- upd_en  in  1  resolve-stage update enable
- upd_inst  in  32  resolved instruction
- upd_index  in  IDX_W  carried pred_index
- upd_ghr  in  HIST_W  carried pred_ghr
- upd_pred  in  1  carried pred_taken
- upd_taken  in  1  actual outcome
- ready  out  1  init sweep finished
- correct_cnt  out  32  correct predictions
- branch_cnt  out  32  branches fetched

Behaviour:
- Branch decode: opcode[31:26]==6'b000001 (bal) or [31:28]==4'b0001 (bs); the same decode applies to fetch_inst and upd_inst.
- Index:
  - MODE=1: fetch_addr[IDX_W+1:2] XOR zero-extended GHR.
  - MODE=0: fetch_addr[IDX_W+1:2].
- Prediction is combinational (0-cycle): pred_taken = MSB of the indexed counter when pred_valid=1. No tri-state output.
- FSM states INIT and RUN; rst forces INIT from any state, including mid-sweep, and restarts the sweep.
  - INIT: one entry per cycle, ptr 0 .. 2**IDX_W-1, written with INIT_VAL = 2**(CW-1)-1 (weakly not-taken).
  - After the last write the FSM moves to RUN and ready=1 the following cycle.
  - While ready=0: pred_valid=0, pred_taken=0, updates ignored, GHR and counters held.
- Reset values: ready=0, GHR=0, correct_cnt=0, branch_cnt=0, ptr=0, pred_valid=0, pred_taken=0.
- Table update (registered), when upd_en & is_branch(upd_inst) & ready:
  - upd_taken=1: counter = min(counter+1, 2**CW-1).
  - upd_taken=0: counter = max(counter-1, 0).
  - At the saturation bound the entry is unchanged.
- Read/write same entry in the same cycle: the read returns the old value (no bypass).
- GHR:
  - Speculative shift on fetch_en & pred_valid: GHR <= {GHR[HIST_W-2:0], pred_taken}.
  - Recovery on mispredict (upd qualifies and upd_taken != upd_pred): GHR <= {upd_ghr[HIST_W-2:0], upd_taken}.
  - If a mispredict and a speculative shift occur in the same cycle, recovery wins and the shift is dropped.
  - For HIST_W=1 the shift reduces to loading the single bit.
  - MODE=0 still maintains the GHR; it is not used for indexing.
- Counters:
  - correct_cnt +1 when the update qualifies and upd_taken==upd_pred.
  - branch_cnt +1 on fetch_en & pred_valid.
  - Both wrap modulo 2**32.
- upd_en=0 or a non-branch upd_inst: no table, GHR or counter change.

Decomposition:
- Package bp_pkg holds:
  - constants BAL_OP=6'b000001 and BS_OP=4'b0001;
  - function is_branch(inst);
  - the MODE encoding localparams.
- Sub-module bp_counter_table: RAM with one combinational read port, one write port, the INIT sweep FSM and ready. The top level holds the GHR, index hashing and counters.

Test Plan (IDX_W=4, HIST_W=4, CW=2 unless stated):
1. rst high 1 cycle, then low -> ready=0 for 16 cycles, then 1. A bal fetched during INIT gives pred_valid=0 and branch_cnt=0. Asserting rst at sweep cycle 7 restarts the 16-cycle sweep.
2. MODE=0, bs at 0x10, three taken updates -> counter 01→10→11→11, pred_taken=1 after the first update. Two not-taken updates -> 01, pred_taken=0. correct_cnt tracks the supplied upd_pred.
3. MODE=1, GHR=0011, fetch_addr=0x14 -> pred_index=0110, pred_ghr=0011. With fetch_en=1 and predicted taken, GHR=0111 next cycle.
4. Mispredict: upd_ghr=1010, upd_pred=1, upd_taken=0, with a simultaneous branch fetch -> GHR=0100 next cycle, correct_cnt unchanged, entry decremented.
5. Same-entry read and write in one cycle: the read shows the old counter, the next cycle shows the new one. fetch_en=0 with a branch -> branch_cnt and GHR unchanged.
6. Non-branch upd_inst (0x0000_0000) with upd_en=1 -> no table, GHR or counter change. Counter 00 with not-taken stays 00.
